// File: rtl/button_digit_counter.sv
// Two-button up/down digit counter (0..MAX_VAL) with synchronizers, debouncers
// and press-and-hold auto-repeat; drives a seven-segment digit input.

module bdc_debounce #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
    end
  end

  // Counter only runs while the synchronized input disagrees with the
  // accepted level, so any glitch shorter than DB_CYCLES restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync_2 == level) begin
      cnt <= '0;
    end else if (cnt == CW'(DB_CYCLES - 1)) begin
      level <= sync_2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// Repeat FSM
//   state  | meaning
//   IDLE   | waiting for a clean rising edge of exactly one button
//   HOLD   | first step issued, timing the hold delay before auto-repeat
//   REPEAT | issuing one step every REPEAT_CYCLES while the button stays held
module button_digit_counter #(
  parameter int DB_CYCLES     = 1000000,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 20000000,
  parameter int MAX_VAL       = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_dn,
  output logic [3:0] num,
  output logic       changed,
  output logic       up_db,
  output logic       dn_db
);

  localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [3:0] MAX_NUM = 4'(MAX_VAL);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [TW-1:0] limit;
  logic          dir_up;
  logic          step_up;
  logic          step_dn;
  logic          up_q;
  logic          dn_q;
  logic          up_rise;
  logic          dn_rise;
  logic          abort;

  bdc_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_up),
    .level (up_db)
  );

  bdc_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dn (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_dn),
    .level (dn_db)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      up_q <= 1'b0;
      dn_q <= 1'b0;
    end else begin
      up_q <= up_db;
      dn_q <= dn_db;
    end
  end

  assign up_rise = up_db & ~up_q;
  assign dn_rise = dn_db & ~dn_q;

  // Leave the hold/repeat states when the latched button drops or the other
  // one joins in.
  assign abort = dir_up ? (~up_db | dn_db) : (~dn_db | up_db);

  always_comb begin
    limit = TW'(REPEAT_CYCLES - 1);
    if (state == HOLD) limit = TW'(HOLD_CYCLES - 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      dir_up  <= 1'b0;
      step_up <= 1'b0;
      step_dn <= 1'b0;
    end else begin
      step_up <= 1'b0;
      step_dn <= 1'b0;
      case (state)
        IDLE: begin
          timer <= '0;
          if (up_rise && !dn_db) begin
            step_up <= 1'b1;
            dir_up  <= 1'b1;
            state   <= HOLD;
          end else if (dn_rise && !up_db) begin
            step_dn <= 1'b1;
            dir_up  <= 1'b0;
            state   <= HOLD;
          end
        end
        HOLD, REPEAT: begin
          if (abort) begin
            timer <= '0;
            state <= IDLE;
          end else if (timer == limit) begin
            step_up <= dir_up;
            step_dn <= ~dir_up;
            timer   <= '0;
            state   <= REPEAT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          timer <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      num     <= 4'd0;
      changed <= 1'b0;
    end else begin
      changed <= step_up | step_dn;
      if (step_up) begin
        num <= (num >= MAX_NUM) ? 4'd0 : num + 4'd1;
      end else if (step_dn) begin
        num <= (num == 4'd0) ? MAX_NUM : num - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_button_digit_counter.sv
// Directed bench for button_digit_counter with short debounce/hold/repeat
// timings so every scenario fits in a few hundred cycles.

module tb_button_digit_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_up;
  logic       btn_dn;
  logic [3:0] num;
  logic       changed;
  logic       up_db;
  logic       dn_db;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit range_bad = 1'b0;
  logic [3:0] chg_vals[$];
  int         chg_cyc[$];

  button_digit_counter #(
    .DB_CYCLES     (4),
    .HOLD_CYCLES   (20),
    .REPEAT_CYCLES (8),
    .MAX_VAL       (9)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_up  (btn_up),
    .btn_dn  (btn_dn),
    .num     (num),
    .changed (changed),
    .up_db   (up_db),
    .dn_db   (dn_db)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every changed pulse with the value it announces.
  always @(negedge clk) begin
    if (changed === 1'b1) begin
      chg_vals.push_back(num);
      chg_cyc.push_back(cyc);
    end
    if (num > 4'd9) range_bad = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit up, input int hold, input int gap);
    if (up) btn_up = 1'b1; else btn_dn = 1'b1;
    tick(hold);
    if (up) btn_up = 1'b0; else btn_dn = 1'b0;
    tick(gap);
  endtask

  task automatic test_reset;
    rst = 1'b1; btn_up = 1'b0; btn_dn = 1'b0;
    tick(3);
    checks++; if (num !== 4'd0) begin failures++; $display("FAIL reset_num got=%0d exp=0", num); end
    checks++; if (changed !== 1'b0) begin failures++; $display("FAIL reset_changed got=%b exp=0", changed); end
    checks++; if (up_db !== 1'b0) begin failures++; $display("FAIL reset_up_db got=%b exp=0", up_db); end
    checks++; if (dn_db !== 1'b0) begin failures++; $display("FAIL reset_dn_db got=%b exp=0", dn_db); end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_single_press;
    chg_vals.delete(); chg_cyc.delete();
    btn_up = 1'b1;
    tick(6);
    checks++; if (num !== 4'd0) begin failures++; $display("FAIL single_early got=%0d exp=0", num); end
    tick(1);
    checks++; if (up_db !== 1'b1) begin failures++; $display("FAIL single_up_db got=%b exp=1", up_db); end
    tick(3);
    checks++; if (num !== 4'd1) begin failures++; $display("FAIL single_num got=%0d exp=1", num); end
    btn_up = 1'b0;
    tick(40);
    checks++; if (num !== 4'd1) begin failures++; $display("FAIL single_no_repeat got=%0d exp=1", num); end
    checks++; if (chg_vals.size() !== 1) begin failures++; $display("FAIL single_pulses got=%0d exp=1", chg_vals.size()); end
    checks++; if (up_db !== 1'b0) begin failures++; $display("FAIL single_release got=%b exp=0", up_db); end
  endtask

  task automatic test_glitch;
    bit seen_db = 1'b0;
    chg_vals.delete(); chg_cyc.delete();
    for (int i = 0; i < 5; i++) begin
      btn_up = 1'b1;
      for (int k = 0; k < 2; k++) begin tick(1); if (up_db) seen_db = 1'b1; end
      btn_up = 1'b0;
      for (int k = 0; k < 4; k++) begin tick(1); if (up_db) seen_db = 1'b1; end
    end
    tick(10);
    checks++; if (seen_db !== 1'b0) begin failures++; $display("FAIL glitch_up_db got=%b exp=0", seen_db); end
    checks++; if (num !== 4'd1) begin failures++; $display("FAIL glitch_num got=%0d exp=1", num); end
    checks++; if (chg_vals.size() !== 0) begin failures++; $display("FAIL glitch_pulses got=%0d exp=0", chg_vals.size()); end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 8; i++) press(1'b1, 10, 10);
    checks++; if (num !== 4'd9) begin failures++; $display("FAIL wrap_reach9 got=%0d exp=9", num); end
    chg_vals.delete(); chg_cyc.delete();
    press(1'b1, 10, 10);
    checks++; if (num !== 4'd0) begin failures++; $display("FAIL wrap_up got=%0d exp=0", num); end
    press(1'b0, 10, 10);
    checks++; if (num !== 4'd9) begin failures++; $display("FAIL wrap_dn got=%0d exp=9", num); end
    checks++; if (chg_vals.size() !== 2) begin failures++; $display("FAIL wrap_pulses got=%0d exp=2", chg_vals.size()); end
  endtask

  task automatic test_repeat;
    logic [3:0] exp_vals [6] = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd9};
    int         exp_gap  [5] = '{20, 8, 8, 8, 8};
    int rel;
    for (int i = 0; i < 4; i++) press(1'b0, 10, 10);
    checks++; if (num !== 4'd5) begin failures++; $display("FAIL repeat_start got=%0d exp=5", num); end
    chg_vals.delete(); chg_cyc.delete();
    btn_dn = 1'b1;
    tick(60);
    btn_dn = 1'b0;
    rel = cyc;
    tick(30);
    checks++;
    if (chg_vals.size() !== 6) begin
      failures++; $display("FAIL repeat_count got=%0d exp=6", chg_vals.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (chg_vals[i] !== exp_vals[i]) begin
          failures++; $display("FAIL repeat_val[%0d] got=%0d exp=%0d", i, chg_vals[i], exp_vals[i]);
        end
      end
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (chg_cyc[i+1] - chg_cyc[i] !== exp_gap[i]) begin
          failures++; $display("FAIL repeat_gap[%0d] got=%0d exp=%0d", i, chg_cyc[i+1] - chg_cyc[i], exp_gap[i]);
        end
      end
      checks++;
      if (chg_cyc[5] > rel + 7) begin
        failures++; $display("FAIL repeat_stop last=%0d limit=%0d", chg_cyc[5], rel + 7);
      end
    end
    checks++; if (num !== 4'd9) begin failures++; $display("FAIL repeat_final got=%0d exp=9", num); end
  endtask

  task automatic test_both;
    chg_vals.delete(); chg_cyc.delete();
    btn_up = 1'b1; btn_dn = 1'b1;
    tick(20);
    checks++; if ({up_db, dn_db} !== 2'b11) begin failures++; $display("FAIL both_db got=%b exp=11", {up_db, dn_db}); end
    checks++; if (num !== 4'd9) begin failures++; $display("FAIL both_num got=%0d exp=9", num); end
    btn_dn = 1'b0;
    tick(40);
    checks++; if (dn_db !== 1'b0) begin failures++; $display("FAIL both_dn_rel got=%b exp=0", dn_db); end
    checks++; if (chg_vals.size() !== 0) begin failures++; $display("FAIL both_no_step got=%0d exp=0", chg_vals.size()); end
    btn_up = 1'b0;
    tick(10);
    press(1'b1, 10, 10);
    checks++; if (num !== 4'd0) begin failures++; $display("FAIL both_fresh got=%0d exp=0", num); end
    checks++; if (chg_vals.size() !== 1) begin failures++; $display("FAIL both_pulses got=%0d exp=1", chg_vals.size()); end
  endtask

  task automatic test_reset_in_repeat;
    btn_up = 1'b1;
    tick(70);
    checks++; if (num !== 4'd7) begin failures++; $display("FAIL rst_rep_pre got=%0d exp=7", num); end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++; if (num !== 4'd0) begin failures++; $display("FAIL rst_rep_num got=%0d exp=0", num); end
    checks++; if (changed !== 1'b0) begin failures++; $display("FAIL rst_rep_changed got=%b exp=0", changed); end
    checks++; if (up_db !== 1'b0) begin failures++; $display("FAIL rst_rep_up_db got=%b exp=0", up_db); end
    chg_vals.delete(); chg_cyc.delete();
    tick(4);
    checks++; if (num !== 4'd0) begin failures++; $display("FAIL rst_rep_wait got=%0d exp=0", num); end
    tick(8);
    checks++; if (num !== 4'd1) begin failures++; $display("FAIL rst_rep_first got=%0d exp=1", num); end
    checks++; if (chg_vals.size() !== 1) begin failures++; $display("FAIL rst_rep_pulses got=%0d exp=1", chg_vals.size()); end
    btn_up = 1'b0;
    tick(20);
  endtask

  initial begin
    rst = 1'b1; btn_up = 1'b0; btn_dn = 1'b0;
    test_reset;
    test_single_press;
    test_glitch;
    test_wrap;
    test_repeat;
    test_both;
    test_reset_in_repeat;
    checks++; if (range_bad !== 1'b0) begin failures++; $display("FAIL num_range got=%b exp=0", range_bad); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
